// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch stage for the MIPS core.
// It holds the PC, runs a held-request/acknowledge handshake to instruction
// memory, and buffers fetched words in a small circular queue toward decode.
// Taken branches and jumps redirect fetch, flush the queue, and discard the
// response of any request still in flight.
module mips_fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                QUEUE_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic [15:0]       branch_off,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic [25:0]       jump_idx,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int                PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(28'hFFF_FFFF);

    // IDLE: nothing outstanding. WAIT: live request. DROP: request whose
    // response must be thrown away because a redirect overtook it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_q [QUEUE_DEPTH];
    logic [DATA_W-1:0] data_d [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pcs_q  [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pcs_d  [QUEUE_DEPTH];

    logic              redirect;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_base;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] target;

    // Redirect target arithmetic (wraps modulo 2^ADDR_W); branch beats jump
    always_comb begin
        branch_tgt = branch_pc + FOUR
                   + {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};
        jump_base  = jump_pc + FOUR;
        jump_tgt   = (jump_base & ~LOW_MASK) | ADDR_W'({jump_idx, 2'b00});
        redirect   = branch_valid | jump_valid;
        target     = branch_valid ? branch_tgt : jump_tgt;
    end

    // Queue push/pop bookkeeping and PC advance; a redirect flushes everything
    always_comb begin
        push       = (state_q == S_WAIT) && imem_ack && !redirect;
        pop        = (count_q != '0) && inst_ready && !redirect;
        data_d     = data_q;
        pcs_d      = pcs_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = target;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = imem_rdata;
                pcs_d[wr_ptr_q]  = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                fetch_pc_d       = fetch_pc_q + FOUR;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Next fetch state; credit is queue occupancy plus the single outstanding slot
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // A redirect empties the queue, so it always leaves credit.
                if (redirect || (count_q < DEPTH_C)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack coinciding with a redirect reissues straight to the
                // target so the new stream starts without a bubble.
                if (imem_ack) begin
                    state_d = (count_d < DEPTH_C) ? S_WAIT : S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request outputs; a dropped request keeps its stale address until acked
    always_comb begin
        req_d  = (state_d != S_IDLE);
        addr_d = (state_d == S_WAIT) ? fetch_pc_d : addr_q;
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, request and queue registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_q     <= data_d;
            pcs_q      <= pcs_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = pcs_q[rd_ptr_q];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed, table-driven bench for mips_fetch_unit with
// RESET_PC = 0x400 and a two-entry queue. The memory model returns
// address ^ 0xC0DE_0000 as the instruction word.
module tb_mips_fetch_unit;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0400;
    localparam logic [31:0] DK  = 32'hC0DE_0000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_pc = '0;
    logic [15:0]   branch_off = '0;
    logic          jump_valid = 1'b0;
    logic [AW-1:0] jump_pc = '0;
    logic [25:0]   jump_idx = '0;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mips_fetch_unit #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RESET_PC   (RPC),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .branch_valid(branch_valid),
        .branch_pc   (branch_pc),
        .branch_off  (branch_off),
        .jump_valid  (jump_valid),
        .jump_pc     (jump_pc),
        .jump_idx    (jump_idx),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    assign imem_rdata = imem_addr ^ DK;

    always #5 clock = ~clock;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        bv;
        logic [31:0] bpc;
        logic [15:0] boff;
        logic        jv;
        logic [31:0] jpc;
        logic [25:0] jidx;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ack, logic ready, logic bv, logic [31:0] bpc,
                                logic [15:0] boff, logic jv, logic [31:0] jpc,
                                logic [25:0] jidx, logic e_req, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.bv = bv; v.bpc = bpc; v.boff = boff;
        v.jv = jv; v.jpc = jpc; v.jidx = jidx; v.e_req = e_req;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic vec_t mks(logic ack, logic ready, logic e_req,
                                 logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc);
        return mk(ack, ready, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 26'h0,
                  e_req, e_addr, e_valid, e_pc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack     = 1'b0;
        inst_ready   = 1'b0;
        branch_valid = 1'b0;
        branch_pc    = '0;
        branch_off   = '0;
        jump_valid   = 1'b0;
        jump_pc      = '0;
        jump_idx     = '0;
    endtask

    // Reset asserted across a clock edge, released on a falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc);
        chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, e_req});
        chk({tag, "_addr"}, imem_addr, e_addr);
        chk({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, e_valid});
        if (e_valid) begin
            chk({tag, "_pc"}, inst_pc, e_pc);
            chk({tag, "_data"}, inst_data, e_pc ^ DK);
        end
    endtask

    initial begin
        // Per-cycle vectors from reset release: backpressure, drain, streaming,
        // branch redirect, simultaneous branch+jump, and address wrap.
        vecs.push_back(mks(1, 0, 1, 32'h400, 0, 32'h0));
        vecs.push_back(mks(1, 0, 1, 32'h404, 1, 32'h400));
        for (int i = 0; i < 8; i++) vecs.push_back(mks(1, 0, 0, 32'h404, 1, 32'h400));
        vecs.push_back(mks(1, 1, 0, 32'h404, 1, 32'h404));
        vecs.push_back(mks(1, 1, 1, 32'h408, 0, 32'h0));
        vecs.push_back(mks(1, 1, 1, 32'h40C, 1, 32'h408));
        vecs.push_back(mks(1, 1, 1, 32'h410, 1, 32'h40C));
        vecs.push_back(mks(1, 1, 1, 32'h414, 1, 32'h410));
        vecs.push_back(mks(1, 1, 1, 32'h418, 1, 32'h414));
        vecs.push_back(mk(1, 1, 1, 32'h100, 16'hFFFE, 0, 32'h0, 26'h0, 1, 32'hFC, 0, 32'h0));
        vecs.push_back(mks(1, 1, 1, 32'h100, 1, 32'hFC));
        vecs.push_back(mks(1, 1, 1, 32'h104, 1, 32'h100));
        vecs.push_back(mk(1, 1, 1, 32'h200, 16'h0010, 1, 32'h1000_0000, 26'h40,
                          1, 32'h244, 0, 32'h0));
        vecs.push_back(mks(1, 1, 1, 32'h248, 1, 32'h244));
        vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFF8, 16'h0000, 0, 32'h0, 26'h0,
                          1, 32'hFFFF_FFFC, 0, 32'h0));
        vecs.push_back(mks(1, 1, 1, 32'h0, 1, 32'hFFFF_FFFC));
        vecs.push_back(mks(1, 1, 1, 32'h4, 1, 32'h0));

        // Reset values while reset_n is held low.
        clear_inputs();
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            imem_ack     = vecs[i].ack;
            inst_ready   = vecs[i].ready;
            branch_valid = vecs[i].bv;
            branch_pc    = vecs[i].bpc;
            branch_off   = vecs[i].boff;
            jump_valid   = vecs[i].jv;
            jump_pc      = vecs[i].jpc;
            jump_idx     = vecs[i].jidx;
            tick();
            chk_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_valid, vecs[i].e_pc);
        end

        // Jump during a wait state; memory acks three cycles after the request.
        do_reset();
        inst_ready = 1'b1;
        tick();
        chk_outs("ws_issue", 1, 32'h400, 0, 32'h0);
        jump_valid = 1'b1;
        jump_pc    = 32'h1000_0000;
        jump_idx   = 26'h40;
        tick();
        chk_outs("ws_drop1", 1, 32'h400, 0, 32'h0);
        jump_valid = 1'b0;
        tick();
        chk_outs("ws_drop2", 1, 32'h400, 0, 32'h0);
        imem_ack = 1'b1;
        tick();
        chk_outs("ws_stale_ack", 0, 32'h400, 0, 32'h0);
        imem_ack = 1'b0;
        tick();
        chk_outs("ws_reissue", 1, 32'h1000_0100, 0, 32'h0);
        imem_ack = 1'b1;
        tick();
        chk_outs("ws_target", 1, 32'h1000_0104, 1, 32'h1000_0100);

        // Asynchronous reset in WAIT with one entry queued.
        do_reset();
        imem_ack = 1'b1;
        tick();
        tick();
        chk_outs("ar_before", 1, 32'h404, 1, 32'h400);
        imem_ack = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_req", {31'b0, imem_req}, 32'h0);
        chk("ar_valid", {31'b0, inst_valid}, 32'h0);
        chk("ar_addr", imem_addr, RPC);
        chk("ar_data", inst_data, 32'h0);
        chk("ar_pc", inst_pc, 32'h0);
        @(negedge clock);
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk_outs("ar_restart", 1, 32'h400, 0, 32'h0);
        tick();
        chk_outs("ar_first", 1, 32'h404, 1, 32'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
